// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, PRId, Config.
// Ports: clk/resetn, ra/rdata read, we/wa/wdata mtc0, exc_*/eret commit, ext_int, int_req/epc/exl.
module cp0_regfile #(
  parameter logic [31:0] PRID   = 32'h0000_4220,
  parameter logic [31:0] CONFIG = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  ra,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [7:0]  wa,
  input  logic [31:0] wdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_badv_we,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  ext_int,
  output logic        int_req,
  output logic [31:0] epc,
  output logic        exl
);

  localparam logic [7:0] A_BADV = 8'h40;
  localparam logic [7:0] A_CNT  = 8'h48;
  localparam logic [7:0] A_CMP  = 8'h58;
  localparam logic [7:0] A_STAT = 8'h60;
  localparam logic [7:0] A_CAUS = 8'h68;
  localparam logic [7:0] A_EPC  = 8'h70;
  localparam logic [7:0] A_PRID = 8'h78;
  localparam logic [7:0] A_CFG  = 8'h80;

  logic [31:0] badv_q, badv_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  hw_q, hw_d;
  logic [1:0]  sw_q, sw_d;
  logic [4:0]  code_q, code_d;
  logic        tick_q, tick_d;
  logic        cwr_q, cwr_d;

  logic        wr;
  logic [7:0]  ip;
  logic [31:0] status_r, cause_r;

  // A commit write is dropped when its instruction is cancelled by an exception.
  assign wr = we & ~exc_valid;

  assign ip = {hw_q[5] | ti_q, hw_q[4:0], sw_q};

  assign status_r = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_r  = {bd_q, ti_q, 14'b0, ip, 1'b0, code_q, 2'b0};

  assign int_req = ie_q & ~exl_q & |(ip & im_q);
  assign epc     = epc_q;
  assign exl     = exl_q;

  always_comb begin
    rdata = 32'b0;
    unique case (ra)
      A_BADV:  rdata = badv_q;
      A_CNT:   rdata = count_q;
      A_CMP:   rdata = compare_q;
      A_STAT:  rdata = status_r;
      A_CAUS:  rdata = cause_r;
      A_EPC:   rdata = epc_q;
      A_PRID:  rdata = PRID;
      A_CFG:   rdata = CONFIG;
      default: rdata = 32'b0;
    endcase
  end

  always_comb begin
    badv_d    = badv_q;
    count_d   = tick_q ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    epc_d     = epc_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    sw_d      = sw_q;
    code_d    = code_q;
    tick_d    = ~tick_q;
    cwr_d     = cwr_q;
    hw_d      = ext_int;
    // Timer match is ignored while Count sits at its untouched reset zero.
    ti_d = ti_q |
      ((count_q == compare_q) && (count_q != 32'b0 || cwr_q));

    if (wr) begin
      unique case (wa)
        A_CNT: begin
          count_d = wdata;
          cwr_d   = 1'b1;
        end
        A_CMP: begin
          compare_d = wdata;
          ti_d      = 1'b0;
        end
        A_STAT: begin
          im_d  = wdata[15:8];
          exl_d = wdata[1];
          ie_d  = wdata[0];
        end
        A_CAUS:  sw_d  = wdata[9:8];
        A_EPC:   epc_d = wdata;
        default: ;
      endcase
    end

    if (eret) exl_d = 1'b0;

    if (exc_valid) begin
      code_d = exc_code;
      exl_d  = 1'b1;
      if (!exl_q) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end
      if (exc_badv_we) badv_d = exc_badvaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      badv_q    <= 32'b0;
      count_q   <= 32'b0;
      compare_q <= 32'b0;
      epc_q     <= 32'b0;
      im_q      <= 8'b0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ti_q      <= 1'b0;
      hw_q      <= 6'b0;
      sw_q      <= 2'b0;
      code_q    <= 5'b0;
      tick_q    <= 1'b0;
      cwr_q     <= 1'b0;
    end else begin
      badv_q    <= badv_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      epc_q     <= epc_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ti_q      <= ti_d;
      hw_q      <= hw_d;
      sw_q      <= sw_d;
      code_q    <= code_d;
      tick_q    <= tick_d;
      cwr_q     <= cwr_d;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed testbench for cp0_regfile.
// One task per feature, inline comparisons, single summary line.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  ra;
  logic [31:0] rdata;
  logic        we;
  logic [7:0]  wa;
  logic [31:0] wdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badv_we;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  ext_int;
  logic        int_req;
  logic [31:0] epc;
  logic        exl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cp0_regfile dut (
    .clk(clk), .resetn(resetn),
    .ra(ra), .rdata(rdata),
    .we(we), .wa(wa), .wdata(wdata),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badv_we(exc_badv_we),
    .exc_badvaddr(exc_badvaddr),
    .eret(eret), .ext_int(ext_int),
    .int_req(int_req), .epc(epc), .exl(exl)
  );

  task automatic step();
    @(posedge clk);
    #1;
    we = 1'b0;
    exc_valid = 1'b0;
    exc_badv_we = 1'b0;
    eret = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    wa = a;
    wdata = d;
    step();
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    ra = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    rd(8'h60, v);
    n_cmp++;
    if (v !== 32'h0040_0000) begin
      n_err++;
      $display("FAIL status_rst got %h exp %h", v, 32'h0040_0000);
    end
    rd(8'h78, v);
    n_cmp++;
    if (v !== 32'h0000_4220) begin
      n_err++;
      $display("FAIL prid got %h exp %h", v, 32'h0000_4220);
    end
    rd(8'h38, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL unmapped got %h exp 0", v);
    end
    n_cmp++;
    if ({int_req, exl, epc} !== 34'h0) begin
      n_err++;
      $display("FAIL out_rst got %b %b %h exp 0 0 0",
               int_req, exl, epc);
    end
  endtask

  task automatic test_count();
    logic [31:0] v;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    rd(8'h48, v);
    n_cmp++;
    if (v !== 32'd5) begin
      n_err++;
      $display("FAIL count_10 got %0d exp 5", v);
    end
    wr(8'h48, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    rd(8'h48, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL count_wrap got %h exp 0", v);
    end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    bit hit;
    do_reset();
    wr(8'h58, 32'd3);
    wr(8'h60, 32'h0000_8001);
    wr(8'h48, 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      rd(8'h48, v);
      if (v == 32'd3) hit = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL count_to_3 timeout got %0d exp 3", v);
    end
    @(posedge clk);
    #1;
    rd(8'h68, v);
    n_cmp++;
    if (v !== 32'h4000_8000) begin
      n_err++;
      $display("FAIL ti_cause got %h exp %h", v, 32'h4000_8000);
    end
    n_cmp++;
    if (int_req !== 1'b1) begin
      n_err++;
      $display("FAIL ti_irq got %b exp 1", int_req);
    end
    wr(8'h58, 32'd10);
    rd(8'h68, v);
    n_cmp++;
    if (v !== 32'h0 || int_req !== 1'b0) begin
      n_err++;
      $display("FAIL ti_clear got %h %b exp 0 0", v, int_req);
    end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    do_reset();
    @(negedge clk);
    exc_valid = 1'b1;
    exc_code = 5'h04;
    exc_pc = 32'hBFC0_0104;
    exc_bd = 1'b1;
    exc_badv_we = 1'b1;
    exc_badvaddr = 32'h0000_0003;
    step();
    n_cmp++;
    if (epc !== 32'hBFC0_0100) begin
      n_err++;
      $display("FAIL exc_epc got %h exp %h", epc, 32'hBFC0_0100);
    end
    rd(8'h68, v);
    n_cmp++;
    if (v !== 32'h8000_0010) begin
      n_err++;
      $display("FAIL exc_cause got %h exp %h", v, 32'h8000_0010);
    end
    rd(8'h40, v);
    n_cmp++;
    if (v !== 32'h3) begin
      n_err++;
      $display("FAIL exc_badv got %h exp 3", v);
    end
    n_cmp++;
    if (exl !== 1'b1) begin
      n_err++;
      $display("FAIL exc_exl got %b exp 1", exl);
    end
    @(negedge clk);
    exc_valid = 1'b1;
    exc_code = 5'h05;
    exc_pc = 32'h8000_0000;
    exc_bd = 1'b0;
    step();
    n_cmp++;
    if (epc !== 32'hBFC0_0100) begin
      n_err++;
      $display("FAIL exc2_epc got %h exp %h", epc, 32'hBFC0_0100);
    end
    rd(8'h68, v);
    n_cmp++;
    if (v !== 32'h8000_0014) begin
      n_err++;
      $display("FAIL exc2_cause got %h exp %h", v, 32'h8000_0014);
    end
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge clk);
    exc_valid = 1'b1;
    exc_code = 5'h0A;
    exc_pc = 32'h0000_0100;
    exc_bd = 1'b0;
    we = 1'b1;
    wa = 8'h70;
    wdata = 32'h0000_1234;
    step();
    n_cmp++;
    if (epc !== 32'h0000_0100) begin
      n_err++;
      $display("FAIL exc_vs_we got %h exp %h", epc, 32'h100);
    end
    @(negedge clk);
    exc_valid = 1'b1;
    eret = 1'b1;
    step();
    n_cmp++;
    if (exl !== 1'b1) begin
      n_err++;
      $display("FAIL exc_vs_eret got %b exp 1", exl);
    end
    @(negedge clk);
    eret = 1'b1;
    step();
    n_cmp++;
    if (exl !== 1'b0) begin
      n_err++;
      $display("FAIL eret got %b exp 0", exl);
    end
    @(negedge clk);
    eret = 1'b1;
    we = 1'b1;
    wa = 8'h60;
    wdata = 32'h0000_0003;
    step();
    n_cmp++;
    if (exl !== 1'b0 || dut.ie_q !== 1'b1) begin
      n_err++;
      $display("FAIL eret_we got exl=%b ie=%b exp 0 1",
               exl, dut.ie_q);
    end
  endtask

  task automatic test_irq_reset();
    logic [31:0] v;
    do_reset();
    wr(8'h60, 32'h0000_0401);
    n_cmp++;
    if (int_req !== 1'b0) begin
      n_err++;
      $display("FAIL irq_idle got %b exp 0", int_req);
    end
    @(negedge clk);
    ext_int = 6'b000001;
    @(posedge clk);
    #1;
    rd(8'h68, v);
    n_cmp++;
    if (v !== 32'h0000_0400 || int_req !== 1'b1) begin
      n_err++;
      $display("FAIL irq_ip2 got %h %b exp %h 1",
               v, int_req, 32'h400);
    end
    do_reset();
    rd(8'h60, v);
    n_cmp++;
    if (int_req !== 1'b0 || v !== 32'h0040_0000) begin
      n_err++;
      $display("FAIL irq_rst got %b %h exp 0 %h",
               int_req, v, 32'h0040_0000);
    end
    ext_int = 6'b0;
  endtask

  initial begin
    resetn = 1'b1;
    ra = 8'h0;
    we = 1'b0;
    wa = 8'h0;
    wdata = 32'h0;
    exc_valid = 1'b0;
    exc_code = 5'h0;
    exc_pc = 32'h0;
    exc_bd = 1'b0;
    exc_badv_we = 1'b0;
    exc_badvaddr = 32'h0;
    eret = 1'b0;
    ext_int = 6'b0;
    test_reset();
    test_count();
    test_timer();
    test_exception();
    test_priority();
    test_irq_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
